branch_sequencer: RTL and testbench
===================================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 flag_we  input  1  ALU flag write strobe; loads O_in/S_in/C_in/Z_in into the flag register.
REQ-005 O_in, S_in, C_in, Z_in  input  1 each  ALU overflow, sign, carry and zero flags.
REQ-006 br_valid  input  1  decode presents a control-transfer instruction.
REQ-007 OP_TF  input  3  000 jf, 001 jt, 010 j, 011 jal, 100 jr, 111 nop; others are nop.
REQ-008 cond  input  3  condition select: 000 true, 001 S, 010 Z, 100 C, 101 S&Z, 111 O; 011/110 false.
REQ-009 br_ready  output  1  sequencer accepts br_valid this cycle.
REQ-010 pc_sel  output  2  00 PC+1, 01 immediate target, 10 register target.
REQ-011 link_we  output  1  write PC+1 into link register.
REQ-012 flush  output  1  squash the instruction fetched after the branch.
REQ-013 taken  output  1  one-cycle pulse per resolved branch, 1 = transfer taken.
REQ-014 flags_q  output  4  registered flags {O,S,C,Z}.

Function
REQ-015 States: IDLE, LINK, FLUSH; br_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance is br_valid & br_ready on a rising edge; the decision resolves on that edge.
REQ-017 Condition value uses flags_q, except when flag_we is high in the accept cycle: then O_in/S_in/C_in/Z_in are used (forwarding).
REQ-018 Decision: jf taken iff condition false; jt taken iff condition true; j, jal, jr always taken; nop never taken.
REQ-019 Not taken: stay IDLE, taken pulses 0, pc_sel 00, no flush.
REQ-020 Taken j/jt/jf: go to FLUSH; pc_sel 01 and flush 1 for exactly that one cycle; return to IDLE.
REQ-021 Taken jr: same as REQ-020 with pc_sel 10.
REQ-022 Taken jal: go to LINK (link_we 1, pc_sel 01, one cycle), then FLUSH (flush 1, pc_sel 01), then IDLE; the total is 2 busy cycles.
REQ-023 taken SHALL be registered and high for the first cycle after acceptance of a taken branch only.
REQ-024 The flag register updates on every flag_we, in any state. A branch in flight keeps its already-made decision.
REQ-025 br_valid while not ready is ignored, with no queuing; decode must hold it.
REQ-026 Outside LINK/FLUSH: pc_sel 00, link_we 0, flush 0.

Reset
REQ-027 reset SHALL immediately force IDLE, flags_q 0000, pc_sel 00, link_we 0, flush 0 and taken 0.
REQ-028 Reset mid-LINK or mid-FLUSH aborts the sequence; no further link_we or flush is issued after release.
REQ-029 The first acceptance is possible on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro BRANCH_STATS_EN: when defined, the module adds outputs br_count[15:0] and taken_count[15:0].
REQ-031 br_count increments per accepted non-nop branch, and taken_count increments per taken branch.
REQ-032 Both counters wrap from FFFF to 0000 and clear on reset.
REQ-033 Without BRANCH_STATS_EN: no counter ports or logic; all other behaviour is identical.

Verification
REQ-034 Scenario 1: flags_q = 0000, jt cond 010 -> taken 0, pc_sel 00, back-to-back accept next cycle.
REQ-035 Scenario 2: flag_we with Z_in=1 in the same cycle as jt cond 010 -> taken 1, FLUSH with pc_sel 01, flags_q = 0001.
REQ-036 Scenario 3: jf cond 101 with S=1, Z=1 -> not taken; with S=1, Z=0 -> taken, flush 1 for one cycle.
REQ-037 Scenario 4: jal -> LINK (link_we 1), then FLUSH, then IDLE; br_ready 0 for 2 cycles; a second br_valid during that window is not accepted until IDLE.
REQ-038 Scenario 5: jr -> pc_sel 10 for one cycle; OP_TF 111 with any cond/flags -> never taken.
REQ-039 Scenario 6: reset asserted mid-LINK of a jal -> all outputs 0 asynchronously, flags_q 0000, no flush after release; with BRANCH_STATS_EN, counters read 0 and 0xFFFF+1 wraps to 0.

Source files
------------

// File: rtl/branch_sequencer.sv
// Branch resolver: accepts one control-transfer per IDLE cycle, decides on the accept edge, registered outputs one cycle later.
// Busy 1 cycle (j/jt/jf/jr) or 2 cycles (jal) with br_ready low; optional counters under BRANCH_STATS_EN.
module branch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        flag_we,
  input  logic        O_in,
  input  logic        S_in,
  input  logic        C_in,
  input  logic        Z_in,
  input  logic        br_valid,
  input  logic [2:0]  OP_TF,
  input  logic [2:0]  cond,
  output logic        br_ready,
  output logic [1:0]  pc_sel,
  output logic        link_we,
  output logic        flush,
  output logic        taken,
  output logic [3:0]  flags_q
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] br_count,
  output logic [15:0] taken_count
`endif
);

  localparam logic [2:0] OP_JF  = 3'b000;
  localparam logic [2:0] OP_JT  = 3'b001;
  localparam logic [2:0] OP_J   = 3'b010;
  localparam logic [2:0] OP_JAL = 3'b011;
  localparam logic [2:0] OP_JR  = 3'b100;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_IMM = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LINK  = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  state_t     state;
  logic [3:0] flags_eff;
  logic       cond_val;
  logic       is_branch;
  logic       br_taken;
  logic       accept;

  // A flag write in the accept cycle is forwarded so the branch sees the newest ALU result.
  always_comb begin
    flags_eff = flag_we ? {O_in, S_in, C_in, Z_in} : flags_q;
    cond_val  = 1'b0;
    case (cond)
      3'b000:  cond_val = 1'b1;
      3'b001:  cond_val = flags_eff[2];
      3'b010:  cond_val = flags_eff[0];
      3'b100:  cond_val = flags_eff[1];
      3'b101:  cond_val = flags_eff[2] & flags_eff[0];
      3'b111:  cond_val = flags_eff[3];
      default: cond_val = 1'b0;
    endcase
  end

  always_comb begin
    is_branch = 1'b0;
    br_taken  = 1'b0;
    case (OP_TF)
      OP_JF:               begin is_branch = 1'b1; br_taken = ~cond_val; end
      OP_JT:               begin is_branch = 1'b1; br_taken = cond_val;  end
      OP_J, OP_JAL, OP_JR: begin is_branch = 1'b1; br_taken = 1'b1;      end
      default:             begin is_branch = 1'b0; br_taken = 1'b0;      end
    endcase
    accept = br_valid & br_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      br_ready <= 1'b1;
      pc_sel   <= PC_INC;
      link_we  <= 1'b0;
      flush    <= 1'b0;
      taken    <= 1'b0;
      flags_q  <= 4'b0000;
    end else begin
      if (flag_we)
        flags_q <= {O_in, S_in, C_in, Z_in};
      // Defaults describe the next IDLE cycle; each state overrides what it drives.
      br_ready <= 1'b1;
      pc_sel   <= PC_INC;
      link_we  <= 1'b0;
      flush    <= 1'b0;
      taken    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && br_taken) begin
            taken    <= 1'b1;
            br_ready <= 1'b0;
            if (OP_TF == OP_JAL) begin
              state   <= ST_LINK;
              link_we <= 1'b1;
              pc_sel  <= PC_IMM;
            end else begin
              state  <= ST_FLUSH;
              flush  <= 1'b1;
              pc_sel <= (OP_TF == OP_JR) ? PC_REG : PC_IMM;
            end
          end
        end
        ST_LINK: begin
          state    <= ST_FLUSH;
          flush    <= 1'b1;
          pc_sel   <= PC_IMM;
          br_ready <= 1'b0;
        end
        ST_FLUSH: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count    <= 16'h0000;
      taken_count <= 16'h0000;
    end else if (accept) begin
      if (is_branch)
        br_count <= br_count + 16'h0001;
      if (br_taken)
        taken_count <= taken_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: expectations queued at drive time, compared after the accept edge.
module tb_branch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       flag_we, O_in, S_in, C_in, Z_in, br_valid;
  logic [2:0] OP_TF, cond;
  logic       br_ready, link_we, flush, taken;
  logic [1:0] pc_sel;
  logic [3:0] flags_q;
`ifdef BRANCH_STATS_EN
  logic [15:0] br_count, taken_count;
`endif

  branch_sequencer dut (
    .clk(clk), .reset(reset), .flag_we(flag_we),
    .O_in(O_in), .S_in(S_in), .C_in(C_in), .Z_in(Z_in),
    .br_valid(br_valid), .OP_TF(OP_TF), .cond(cond),
    .br_ready(br_ready), .pc_sel(pc_sel), .link_we(link_we),
    .flush(flush), .taken(taken), .flags_q(flags_q)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .taken_count(taken_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       tk;
    logic [1:0] pc;
    logic       jal;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] mflags;
  int         mbr, mtk;

  localparam logic [2:0] JF = 3'b000, JT = 3'b001, J = 3'b010, JAL = 3'b011, JR = 3'b100, NOP = 3'b111;

  function automatic logic cond_f(input logic [2:0] c, input logic [3:0] f);
    case (c)
      3'd0: return 1'b1;
      3'd1: return f[2];
      3'd2: return f[0];
      3'd4: return f[1];
      3'd5: return f[2] & f[0];
      3'd7: return f[3];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic decide(input logic [2:0] op, input logic cv);
    case (op)
      JF: return ~cv;
      JT: return cv;
      J, JAL, JR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Packed as {br_ready, taken, pc_sel, link_we, flush}.
  task automatic outs(input string tag, input logic tk, input logic [1:0] pc,
                      input logic lk, input logic fl, input logic rdy);
    check(tag, {10'd0, br_ready, taken, pc_sel, link_we, flush}, {10'd0, rdy, tk, pc, lk, fl});
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] c, input logic fwe, input logic [3:0] fin);
    exp_t e;
    logic [3:0] f;
    logic t;
    br_valid = 1'b1; OP_TF = op; cond = c; flag_we = fwe;
    {O_in, S_in, C_in, Z_in} = fin;
    f = fwe ? fin : mflags;
    t = decide(op, cond_f(c, f));
    if (fwe) mflags = fin;
    e.tk  = t;
    e.jal = t && (op == JAL);
    e.pc  = !t ? 2'b00 : ((op == JR) ? 2'b10 : 2'b01);
    sbq.push_back(e);
    if (op <= JR) mbr++;
    if (t) mtk++;
  endtask

  task automatic accept_check(input string tag);
    exp_t e;
    tick;
    br_valid = 1'b0; flag_we = 1'b0;
    check({tag, ".sb"}, 16'(sbq.size() != 0), 16'd1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    outs({tag, ".c1"}, e.tk, e.pc, e.jal, e.tk && !e.jal, !e.tk);
    if (e.tk) begin
      if (e.jal) begin
        tick;
        outs({tag, ".flush"}, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
      end
      tick;
      outs({tag, ".idle"}, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic setflags(input string tag, input logic [3:0] fin);
    flag_we = 1'b1; {O_in, S_in, C_in, Z_in} = fin; mflags = fin;
    tick;
    flag_we = 1'b0;
    check(tag, {12'd0, flags_q}, {12'd0, mflags});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    reset = 1'b1; br_valid = 1'b0; flag_we = 1'b0;
    {O_in, S_in, C_in, Z_in} = 4'b0000;
    OP_TF = NOP; cond = 3'b000;
    mflags = 4'b0000; mbr = 0; mtk = 0;
    #2;
    outs("reset_outs", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    check("reset_flags", {12'd0, flags_q}, 16'd0);
    tick;
    reset = 1'b0;

    // Scenario 1: not-taken jt, then a back-to-back taken j.
    drive(JT, 3'b010, 1'b0, 4'b0000); accept_check("s1_jt_nt");
    drive(J, 3'b000, 1'b0, 4'b0000);  accept_check("s1_b2b_j");

    // Scenario 2: forwarded Z makes jt taken; forwarded Z=0 overrides stored Z=1.
    drive(JT, 3'b010, 1'b1, 4'b0001); accept_check("s2_fwd_t");
    check("s2_flags", {12'd0, flags_q}, 16'h0001);
    drive(JT, 3'b010, 1'b1, 4'b0000); accept_check("s2_fwd_nt");

    // Scenario 3: jf on S&Z, plus other condition selects.
    setflags("s3_flags_sz", 4'b0101);
    drive(JF, 3'b101, 1'b0, 4'b0000); accept_check("s3_jf_nt");
    setflags("s3_flags_s", 4'b0100);
    drive(JF, 3'b101, 1'b0, 4'b0000); accept_check("s3_jf_t");
    drive(JF, 3'b011, 1'b0, 4'b0000); accept_check("s3_jf_false");
    drive(JT, 3'b001, 1'b0, 4'b0000); accept_check("s3_jt_s");
    drive(JT, 3'b111, 1'b1, 4'b1000); accept_check("s3_jt_o");
    drive(JT, 3'b100, 1'b0, 4'b0000); accept_check("s3_jt_c_nt");
    drive(JT, 3'b110, 1'b1, 4'b1111); accept_check("s3_jt_110_nt");

    // Scenario 4: jal with a second branch held during the busy window.
    setflags("s4_flags0", 4'b0000);
    drive(JAL, 3'b000, 1'b0, 4'b0000);
    tick;
    e = sbq.pop_front();
    br_valid = 1'b1; OP_TF = J; cond = 3'b000;
    flag_we = 1'b1; {O_in, S_in, C_in, Z_in} = 4'b1111; mflags = 4'b1111;
    outs("s4_link", e.tk, e.pc, 1'b1, 1'b0, 1'b0);
    tick;
    flag_we = 1'b0;
    outs("s4_flush", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    check("s4_flags_busy", {12'd0, flags_q}, 16'h000F);
    tick;
    outs("s4_idle_held", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    drive(J, 3'b000, 1'b0, 4'b0000); accept_check("s4_second_j");

    // Scenario 5: jr, then every nop flavour.
    drive(JR, 3'b000, 1'b0, 4'b0000); accept_check("s5_jr");
    for (int c = 0; c < 8; c++) begin
      drive(NOP, 3'(c), 1'b1, 4'b1111); accept_check("s5_nop");
    end
    drive(3'b101, 3'b000, 1'b0, 4'b0000); accept_check("s5_op101");
    drive(3'b110, 3'b000, 1'b0, 4'b0000); accept_check("s5_op110");
`ifdef BRANCH_STATS_EN
    check("s5_br_count", br_count, 16'(mbr));
    check("s5_taken_count", taken_count, 16'(mtk));
`endif

    // Scenario 6: reset in the middle of LINK.
    drive(JAL, 3'b000, 1'b0, 4'b0000);
    tick;
    br_valid = 1'b0;
    e = sbq.pop_front();
    outs("s6_link", e.tk, e.pc, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    outs("s6_async", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    check("s6_flags", {12'd0, flags_q}, 16'd0);
    mflags = 4'b0000; mbr = 0; mtk = 0;
`ifdef BRANCH_STATS_EN
    check("s6_br_count_rst", br_count, 16'd0);
    check("s6_taken_count_rst", taken_count, 16'd0);
`endif
    tick;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      outs("s6_post", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    end
    drive(J, 3'b000, 1'b0, 4'b0000); accept_check("s6_after_j");

`ifdef BRANCH_STATS_EN
    // br_count is 1 here; 65535 not-taken accepts carry it through FFFF to 0.
    br_valid = 1'b1; OP_TF = JT; cond = 3'b011; flag_we = 1'b0;
    repeat (65534) tick;
    check("wrap_ffff", br_count, 16'hFFFF);
    tick;
    br_valid = 1'b0;
    check("wrap_zero", br_count, 16'h0000);
    check("wrap_taken", taken_count, 16'h0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
